sc_orresult_fifo: RTL and testbench
===================================

SC_ORRESULT_FIFO -- requirements
Module: sc_orresult_fifo

Interface
REQ-001 The block SHALL have parameter NUMBER_DATAWIDTH, default 8: width of each stored OR result.
REQ-002 The block SHALL have parameter NUMBER_DEPTH, default 4: entry count, power of two, minimum 2.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port SC_ORRESULT_FIFO_CLOCK_50, in, 1: rising-edge clock.
REQ-005 The block SHALL have port SC_ORRESULT_FIFO_RESET_InHigh, in, 1: asynchronous active-high reset.
REQ-006 The block SHALL have port SC_ORRESULT_FIFO_clear_InHigh, in, 1: synchronous flush.
REQ-007 The block SHALL have port SC_ORRESULT_FIFO_data_In, in, NUMBER_DATAWIDTH: result from the upstream OR stage.
REQ-008 The block SHALL have port SC_ORRESULT_FIFO_push_InHigh, in, 1: write request.
REQ-009 The block SHALL have port SC_ORRESULT_FIFO_pop_InHigh, in, 1: read request.
REQ-010 The block SHALL have port SC_ORRESULT_FIFO_data_Out, out, NUMBER_DATAWIDTH: head entry.
REQ-011 The block SHALL have port SC_ORRESULT_FIFO_count_Out, out, log2(NUMBER_DEPTH)+1: occupancy.
REQ-012 The block SHALL have ports SC_ORRESULT_FIFO_empty_Out and SC_ORRESULT_FIFO_full_Out, out, 1 each: occupancy flags.
REQ-013 The block SHALL have ports SC_ORRESULT_FIFO_overflow_Out and SC_ORRESULT_FIFO_underflow_Out, out, 1 each: sticky error flags.

Function
REQ-014 The FSM SHALL have three states: EMPTY (count 0), PARTIAL (0<count<DEPTH), and FULL (count DEPTH).
REQ-015 The FSM SHALL make these transitions: EMPTY->PARTIAL on push, except DEPTH=... never direct to FULL; PARTIAL->FULL on push-only at count DEPTH-1; PARTIAL->EMPTY on pop-only at count 1; FULL->PARTIAL on pop-only.
REQ-016 A push with the FIFO not full SHALL write data_In at the write pointer on the clock edge; the entry is visible on data_Out the next cycle if the FIFO was empty.
REQ-017 A pop with the FIFO not empty SHALL advance the read pointer; data_Out SHALL be combinational from the head entry (first-word fall-through, zero-latency read).
REQ-018 data_Out SHALL be all-zero while empty.
REQ-019 Pointers SHALL wrap modulo NUMBER_DEPTH.
REQ-020 Push and pop in the same cycle while PARTIAL SHALL perform both; count is unchanged.
REQ-021 Push and pop in the same cycle while FULL SHALL perform both; the FIFO stays FULL and overflow is not set.
REQ-022 Push and pop in the same cycle while EMPTY SHALL perform the push only; the pop is ignored and underflow is set.
REQ-023 A push while FULL without a pop SHALL drop the data, leave the state unchanged, and set overflow.
REQ-024 A pop while EMPTY SHALL be ignored and SHALL set underflow.
REQ-025 overflow and underflow SHALL hold until reset or clear.
REQ-026 clear SHALL have priority over push and pop: pointers, count, and flags go to 0 and the state goes to EMPTY next cycle.
REQ-027 empty_Out and full_Out SHALL be decoded from the state register, glitch-free.

Reset
REQ-028 Reset SHALL asynchronously force state EMPTY, pointers and count to 0, empty_Out=1, full_Out=0, overflow=0, underflow=0, and data_Out=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-030 Reset deassertion SHALL be synchronous to the clock by the integrator.

Configuration
REQ-031 Macro SC_ORRESULT_FIFO_PARITY_EN defined: each entry SHALL store an extra even-parity bit computed from data_In at push, and output SC_ORRESULT_FIFO_parity_Out, 1, SHALL present the head's parity bit (0 when empty).
REQ-032 Macro SC_ORRESULT_FIFO_PARITY_EN undefined: parity storage and the parity_Out port SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package sc_orresult_pkg SHALL hold the FSM state encoding (EMPTY=2'b00, PARTIAL=2'b01, FULL=2'b10) and default width/depth constants.
REQ-034 Storage SHALL be sub-module sc_orresult_mem: a register array with one write port and one asynchronous read port, no reset on data.

Verification
REQ-035 The bench SHALL check: reset, then push 0x0F, 0xF0, 0xAA, 0x55 -> full_Out=1, count=4, data_Out=0x0F.
REQ-036 The bench SHALL check: from FULL, push 0x77 without pop -> overflow=1, data dropped; pops return 0x0F, 0xF0, 0xAA, 0x55, then empty_Out=1.
REQ-037 The bench SHALL check: EMPTY, simultaneous push 0x3C and pop -> count=1, data_Out=0x3C, underflow=1.
REQ-038 The bench SHALL check: FULL, simultaneous push 0x99 and pop -> count stays 4, head advances, 0x99 becomes the last entry read, overflow=0.
REQ-039 The bench SHALL check: pointer wrap after 10 alternating push/pop pairs -> data order preserved, count never exceeds 1.
REQ-040 The bench SHALL check: reset asserted mid-burst at count=3 -> outputs immediately at reset values; with PARITY_EN, push 0x07 -> parity_Out=1.

Source files
------------

// File: rtl/sc_orresult_pkg.sv
// rtl/sc_orresult_pkg.sv - shared state encoding and default sizes for the OR-result FIFO
// Purpose: FSM state type and default width/depth constants used by the FIFO,
//          its interface and its storage.
// Ports:   none (package).
package sc_orresult_pkg;

  // Occupancy states; the encoding is fixed so that external tools decode it consistently.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PARTIAL = 2'b01,
    FULL    = 2'b10
  } state_e;

  localparam int DEFAULT_DATAWIDTH = 8;
  localparam int DEFAULT_DEPTH     = 4;

endpackage

// File: rtl/sc_orresult_fifo_if.sv
// rtl/sc_orresult_fifo_if.sv - push/pop/status bundle of the OR-result FIFO
// Purpose: groups the FIFO request inputs and status outputs.
// Ports:   slave modport (FIFO side) takes clear/data/push/pop and drives
//          data/count/empty/full/overflow/underflow (+ parity when
//          SC_ORRESULT_FIFO_PARITY_EN is defined); master modport is the mirror.
interface sc_orresult_fifo_if
  import sc_orresult_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int NUMBER_DEPTH     = DEFAULT_DEPTH
);
  localparam int CountWidth = $clog2(NUMBER_DEPTH) + 1;

  logic                        SC_ORRESULT_FIFO_clear_InHigh;
  logic [NUMBER_DATAWIDTH-1:0] SC_ORRESULT_FIFO_data_In;
  logic                        SC_ORRESULT_FIFO_push_InHigh;
  logic                        SC_ORRESULT_FIFO_pop_InHigh;
  logic [NUMBER_DATAWIDTH-1:0] SC_ORRESULT_FIFO_data_Out;
  logic [CountWidth-1:0]       SC_ORRESULT_FIFO_count_Out;
  logic                        SC_ORRESULT_FIFO_empty_Out;
  logic                        SC_ORRESULT_FIFO_full_Out;
  logic                        SC_ORRESULT_FIFO_overflow_Out;
  logic                        SC_ORRESULT_FIFO_underflow_Out;
`ifdef SC_ORRESULT_FIFO_PARITY_EN
  logic                        SC_ORRESULT_FIFO_parity_Out;
`endif

  modport slave (
    input  SC_ORRESULT_FIFO_clear_InHigh,
    input  SC_ORRESULT_FIFO_data_In,
    input  SC_ORRESULT_FIFO_push_InHigh,
    input  SC_ORRESULT_FIFO_pop_InHigh,
    output SC_ORRESULT_FIFO_data_Out,
    output SC_ORRESULT_FIFO_count_Out,
    output SC_ORRESULT_FIFO_empty_Out,
    output SC_ORRESULT_FIFO_full_Out,
    output SC_ORRESULT_FIFO_overflow_Out,
`ifdef SC_ORRESULT_FIFO_PARITY_EN
    output SC_ORRESULT_FIFO_parity_Out,
`endif
    output SC_ORRESULT_FIFO_underflow_Out
  );

  modport master (
    output SC_ORRESULT_FIFO_clear_InHigh,
    output SC_ORRESULT_FIFO_data_In,
    output SC_ORRESULT_FIFO_push_InHigh,
    output SC_ORRESULT_FIFO_pop_InHigh,
    input  SC_ORRESULT_FIFO_data_Out,
    input  SC_ORRESULT_FIFO_count_Out,
    input  SC_ORRESULT_FIFO_empty_Out,
    input  SC_ORRESULT_FIFO_full_Out,
    input  SC_ORRESULT_FIFO_overflow_Out,
`ifdef SC_ORRESULT_FIFO_PARITY_EN
    input  SC_ORRESULT_FIFO_parity_Out,
`endif
    input  SC_ORRESULT_FIFO_underflow_Out
  );

endinterface

// File: rtl/sc_orresult_mem.sv
// rtl/sc_orresult_mem.sv - register-array storage for the OR-result FIFO
// Purpose: one synchronous write port, one asynchronous read port, no reset on data.
// Ports:   clk_i, we_i, waddr_i, wdata_i (write); raddr_i -> rdata_o (read).
module sc_orresult_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sc_orresult_fifo.sv
// rtl/sc_orresult_fifo.sv - first-word fall-through FIFO for OR-stage results
// Purpose: buffers OR results with EMPTY/PARTIAL/FULL FSM, sticky overflow and
//          underflow flags and a synchronous flush. Optional even-parity per
//          entry when SC_ORRESULT_FIFO_PARITY_EN is defined.
// Ports:   SC_ORRESULT_FIFO_CLOCK_50 (rising-edge clock),
//          SC_ORRESULT_FIFO_RESET_InHigh (async active-high reset),
//          fifo_if (slave modport: requests in, data/status out).
module sc_orresult_fifo
  import sc_orresult_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int NUMBER_DEPTH     = DEFAULT_DEPTH
) (
  input logic               SC_ORRESULT_FIFO_CLOCK_50,
  input logic               SC_ORRESULT_FIFO_RESET_InHigh,
  sc_orresult_fifo_if.slave fifo_if
);

  localparam int AW = $clog2(NUMBER_DEPTH);
  localparam int CW = AW + 1;
`ifdef SC_ORRESULT_FIFO_PARITY_EN
  localparam int EW = NUMBER_DATAWIDTH + 1;
`else
  localparam int EW = NUMBER_DATAWIDTH;
`endif
  localparam logic [CW-1:0] CountLast = CW'(NUMBER_DEPTH - 1);
  localparam logic [CW-1:0] CountOne  = CW'(1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, full_q;
  logic            overflow_q, underflow_q;
  logic            push_ok, pop_ok, ovf_hit, udf_hit;
  logic [EW-1:0]   wr_data, rd_data;

  always_comb begin
    pop_ok  = fifo_if.SC_ORRESULT_FIFO_pop_InHigh && (state_q != EMPTY);
    // When full, a push is only accepted if a pop frees the head slot this cycle.
    push_ok = fifo_if.SC_ORRESULT_FIFO_push_InHigh && ((state_q != FULL) || pop_ok);
    ovf_hit = fifo_if.SC_ORRESULT_FIFO_push_InHigh && !push_ok;
    udf_hit = fifo_if.SC_ORRESULT_FIFO_pop_InHigh && (state_q == EMPTY);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);

    state_d = state_q;
    case (state_q)
      EMPTY:   if (push_ok) state_d = PARTIAL;
      PARTIAL: begin
        if (push_ok && !pop_ok && (count_q == CountLast)) state_d = FULL;
        else if (pop_ok && !push_ok && (count_q == CountOne)) state_d = EMPTY;
      end
      FULL:    if (pop_ok && !push_ok) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge SC_ORRESULT_FIFO_CLOCK_50 or posedge SC_ORRESULT_FIFO_RESET_InHigh) begin
    if (SC_ORRESULT_FIFO_RESET_InHigh) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (fifo_if.SC_ORRESULT_FIFO_clear_InHigh) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      // Flags are registered alongside the state so they never glitch.
      empty_q     <= (state_d == EMPTY);
      full_q      <= (state_d == FULL);
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      overflow_q  <= overflow_q | ovf_hit;
      underflow_q <= underflow_q | udf_hit;
    end
  end

`ifdef SC_ORRESULT_FIFO_PARITY_EN
  assign wr_data = {^fifo_if.SC_ORRESULT_FIFO_data_In, fifo_if.SC_ORRESULT_FIFO_data_In};
  assign fifo_if.SC_ORRESULT_FIFO_parity_Out = empty_q ? 1'b0 : rd_data[NUMBER_DATAWIDTH];
`else
  assign wr_data = fifo_if.SC_ORRESULT_FIFO_data_In;
`endif

  sc_orresult_mem #(
    .WIDTH (EW),
    .DEPTH (NUMBER_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (SC_ORRESULT_FIFO_CLOCK_50),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Head entry is read combinationally; forced to zero so stale storage never leaks out.
  assign fifo_if.SC_ORRESULT_FIFO_data_Out      = empty_q ? '0 : rd_data[NUMBER_DATAWIDTH-1:0];
  assign fifo_if.SC_ORRESULT_FIFO_count_Out     = count_q;
  assign fifo_if.SC_ORRESULT_FIFO_empty_Out     = empty_q;
  assign fifo_if.SC_ORRESULT_FIFO_full_Out      = full_q;
  assign fifo_if.SC_ORRESULT_FIFO_overflow_Out  = overflow_q;
  assign fifo_if.SC_ORRESULT_FIFO_underflow_Out = underflow_q;

endmodule

// File: tb/tb_sc_orresult_fifo.sv
// tb/tb_sc_orresult_fifo.sv - self-checking bench for sc_orresult_fifo
module tb_sc_orresult_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  always #5 clk = ~clk;

  sc_orresult_fifo_if #(.NUMBER_DATAWIDTH(W), .NUMBER_DEPTH(D)) bus ();

  sc_orresult_fifo #(.NUMBER_DATAWIDTH(W), .NUMBER_DEPTH(D)) dut (
    .SC_ORRESULT_FIFO_CLOCK_50     (clk),
    .SC_ORRESULT_FIFO_RESET_InHigh (rst),
    .fifo_if                       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".data"},  32'(bus.SC_ORRESULT_FIFO_data_Out), 32'(head));
    chk({tag, ".count"}, 32'(bus.SC_ORRESULT_FIFO_count_Out), q.size());
    chk({tag, ".empty"}, 32'(bus.SC_ORRESULT_FIFO_empty_Out), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(bus.SC_ORRESULT_FIFO_full_Out), 32'(q.size() == D));
    chk({tag, ".ovf"},   32'(bus.SC_ORRESULT_FIFO_overflow_Out), 32'(m_ovf));
    chk({tag, ".udf"},   32'(bus.SC_ORRESULT_FIFO_underflow_Out), 32'(m_udf));
`ifdef SC_ORRESULT_FIFO_PARITY_EN
    chk({tag, ".par"},   32'(bus.SC_ORRESULT_FIFO_parity_Out), 32'((q.size() > 0) ? ^head : 1'b0));
`endif
  endtask

  // One clock: drive at negedge, update reference at posedge, sample 1 time unit later.
  task automatic cyc(input logic clr, input logic push, input logic pop, input logic [W-1:0] d,
                     input string tag);
    bit can_pop, can_push;
    @(negedge clk);
    bus.SC_ORRESULT_FIFO_clear_InHigh = clr;
    bus.SC_ORRESULT_FIFO_push_InHigh  = push;
    bus.SC_ORRESULT_FIFO_pop_InHigh   = pop;
    bus.SC_ORRESULT_FIFO_data_In      = d;
    @(posedge clk);
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      can_pop  = pop && (q.size() > 0);
      can_push = push && ((q.size() < D) || can_pop);
      if (push && !can_push) m_ovf = 1'b1;
      if (pop && q.size() == 0) m_udf = 1'b1;
      if (can_pop) void'(q.pop_front());
      if (can_push) q.push_back(d);
    end
    #1;
    check_all(tag);
    @(negedge clk);
    bus.SC_ORRESULT_FIFO_clear_InHigh = 1'b0;
    bus.SC_ORRESULT_FIFO_push_InHigh  = 1'b0;
    bus.SC_ORRESULT_FIFO_pop_InHigh   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] fill [4];
    logic [W-1:0] v;
    fill[0] = 8'h0F; fill[1] = 8'hF0; fill[2] = 8'hAA; fill[3] = 8'h55;
    bus.SC_ORRESULT_FIFO_clear_InHigh = 1'b0;
    bus.SC_ORRESULT_FIFO_push_InHigh  = 1'b0;
    bus.SC_ORRESULT_FIFO_pop_InHigh   = 1'b0;
    bus.SC_ORRESULT_FIFO_data_In      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill to FULL
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, fill[i], "fill");
    chk("fill.full_lit",  32'(bus.SC_ORRESULT_FIFO_full_Out), 32'd1);
    chk("fill.count_lit", 32'(bus.SC_ORRESULT_FIFO_count_Out), 32'd4);
    chk("fill.head_lit",  32'(bus.SC_ORRESULT_FIFO_data_Out), 32'h0F);

    // Push while FULL: dropped, overflow set
    cyc(1'b0, 1'b1, 1'b0, 8'h77, "ovf");
    chk("ovf.flag_lit", 32'(bus.SC_ORRESULT_FIFO_overflow_Out), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain.head_lit", 32'(bus.SC_ORRESULT_FIFO_data_Out), 32'(fill[i]));
      cyc(1'b0, 1'b0, 1'b1, '0, "drain");
    end
    chk("drain.empty_lit", 32'(bus.SC_ORRESULT_FIFO_empty_Out), 32'd1);

    // Flush, then push+pop while EMPTY
    cyc(1'b1, 1'b0, 1'b0, '0, "clear1");
    cyc(1'b0, 1'b1, 1'b1, 8'h3C, "emptypp");
    chk("emptypp.count_lit", 32'(bus.SC_ORRESULT_FIFO_count_Out), 32'd1);
    chk("emptypp.data_lit",  32'(bus.SC_ORRESULT_FIFO_data_Out), 32'h3C);
    chk("emptypp.udf_lit",   32'(bus.SC_ORRESULT_FIFO_underflow_Out), 32'd1);

    // push+pop while FULL
    for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, fill[i], "refill");
    cyc(1'b0, 1'b1, 1'b1, 8'h99, "fullpp");
    chk("fullpp.count_lit", 32'(bus.SC_ORRESULT_FIFO_count_Out), 32'd4);
    chk("fullpp.head_lit",  32'(bus.SC_ORRESULT_FIFO_data_Out), 32'hF0);
    chk("fullpp.ovf_lit",   32'(bus.SC_ORRESULT_FIFO_overflow_Out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      v = bus.SC_ORRESULT_FIFO_data_Out;
      cyc(1'b0, 1'b0, 1'b1, '0, "fulldrain");
    end
    chk("fullpp.last_lit", 32'(v), 32'h99);

    // Pointer wrap with alternating push/pop
    cyc(1'b1, 1'b0, 1'b0, '0, "clear2");
    for (int i = 0; i < 10; i++) begin
      v = W'($urandom);
      cyc(1'b0, 1'b1, 1'b0, v, "wrap.push");
      chk("wrap.head", 32'(bus.SC_ORRESULT_FIFO_data_Out), 32'(v));
      chk("wrap.cnt_le1", 32'(bus.SC_ORRESULT_FIFO_count_Out <= 1), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, '0, "wrap.pop");
    end

    // Asynchronous reset mid-burst at count 3
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, W'($urandom), "burst");
    chk("burst.count_lit", 32'(bus.SC_ORRESULT_FIFO_count_Out), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all("asyncrst");
    @(negedge clk);
    rst = 1'b0;

`ifdef SC_ORRESULT_FIFO_PARITY_EN
    cyc(1'b0, 1'b1, 1'b0, 8'h07, "parity");
    chk("parity.lit", 32'(bus.SC_ORRESULT_FIFO_parity_Out), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, '0, "clear3");
`endif

    // Randomised traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), W'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
